muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit, XLEN-parametrised; extends the single-cycle ALU op set.

---
 rtl/muldiv_unit_pkg.sv | 40 ++++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    // Operation encoding follows the RV32M funct3 field directly.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } md_state_t;

    // funct7 value that selects the M extension under OPCODE_OP.
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic op_is_div(input md_op_t op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic rs1_is_signed(input md_op_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic rs2_is_signed(input md_op_t op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. Operands are reduced to magnitudes on
// accept, one bit is processed per cycle through a single shared
// adder/subtractor, and the sign is restored on the last iteration.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t        state_reg;
    md_op_t           op_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             neg_q_reg;   // negate product / quotient at the end
    logic             neg_r_reg;   // negate remainder at the end
    logic [CNT_W-1:0] count_reg;
    logic [XLEN-1:0]  hi_reg;      // product high half / partial remainder
    logic [XLEN-1:0]  lo_reg;      // multiplier bits / dividend bits -> quotient
    logic [XLEN-1:0]  mcand_reg;   // multiplicand or divisor magnitude
    logic [XLEN-1:0]  result_reg;

    // ---------------- accept-side decode ----------------
    md_op_t          op_in;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special_hit;
    logic [XLEN-1:0] special_result;

    assign op_in = md_op_t'(op_i);
    assign a_neg = rs1_is_signed(op_in) & rs1_i[XLEN-1];
    assign b_neg = rs2_is_signed(op_in) & rs2_i[XLEN-1];
    assign a_mag = a_neg ? -rs1_i : rs1_i;
    assign b_mag = b_neg ? -rs2_i : rs2_i;

    // Divide by zero and signed overflow bypass the iteration entirely.
    assign div_zero    = op_is_div(op_in) && (rs2_i == '0);
    assign div_ovf     = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                         (rs1_i == MIN_NEG) && (rs2_i == '1);
    assign special_hit = div_zero || div_ovf;

    // funct3[1] separates REM* from DIV* within the divide group.
    assign special_result = div_zero ? (op_in[1] ? rs1_i : '1)
                                     : (op_in[1] ? '0 : rs1_i);

    // ---------------- shared adder / subtractor ----------------
    logic            is_div;
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   add_x;
    logic [XLEN:0]   add_y;
    logic [XLEN+1:0] add_sum;
    logic            q_bit;
    logic [XLEN-1:0] hi_step;
    logic [XLEN-1:0] lo_step;

    assign is_div = op_is_div(op_reg);

    // Multiply adds the multiplicand only when the current multiplier bit is set.
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & (is_div | lo_reg[0]);
        end
    endgenerate

    // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
    assign add_x   = is_div ? {hi_reg, lo_reg[XLEN-1]} : {1'b0, hi_reg};
    assign add_y   = {1'b0, addend};
    assign add_sum = {1'b0, add_x} + {1'b0, (is_div ? ~add_y : add_y)} + {{(XLEN+1){1'b0}}, is_div};

    // Carry out of the subtract means no borrow: the divisor fits.
    assign q_bit   = add_sum[XLEN+1];
    assign hi_step = is_div ? (q_bit ? add_sum[XLEN-1:0] : add_x[XLEN-1:0]) : add_sum[XLEN:1];
    assign lo_step = is_div ? {lo_reg[XLEN-2:0], q_bit} : {add_sum[0], lo_reg[XLEN-1:1]};

    // ---------------- sign fixup and result select ----------------
    logic [2*XLEN-1:0] prod_full;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_result;

    assign prod_full = {hi_step, lo_step};
    assign prod_fix  = neg_q_reg ? -prod_full : prod_full;
    assign quot_fix  = neg_q_reg ? -lo_step : lo_step;
    assign rem_fix   = neg_r_reg ? -hi_step : hi_step;

    // Pick the architectural result from the values produced by the final iteration.
    always_comb begin
        final_result = '0;
        case (op_reg)
            MD_MUL:                      final_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             final_result = quot_fix;
            MD_REM, MD_REMU:             final_result = rem_fix;
            default:                     final_result = '0;
        endcase
    end

    // Control FSM and datapath registers; flush and reset both abandon any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= MD_IDLE;
            op_reg     <= MD_MUL;
            tag_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            mcand_reg  <= '0;
            result_reg <= '0;
        end else if (flush_i) begin
            state_reg <= MD_IDLE;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (in_valid) begin
                        op_reg    <= op_in;
                        tag_reg   <= tag_i;
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                        hi_reg    <= '0;
                        lo_reg    <= op_is_div(op_in) ? a_mag : b_mag;
                        mcand_reg <= op_is_div(op_in) ? b_mag : a_mag;
                        count_reg <= CNT_W'(XLEN-1);
                        if (special_hit) begin
                            result_reg <= special_result;
                            state_reg  <= MD_DONE;
                        end else begin
                            state_reg  <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    hi_reg <= hi_step;
                    lo_reg <= lo_step;
                    if (count_reg == '0) begin
                        result_reg <= final_result;
                        state_reg  <= MD_DONE;
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    if (out_ready) begin
                        state_reg <= MD_IDLE;
                    end
                end
                default: state_reg <= MD_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == MD_IDLE);
    assign out_valid = (state_reg == MD_DONE);
    assign busy_o    = (state_reg != MD_IDLE);
    assign result_o  = result_reg;
    assign tag_o     = tag_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors scored against an arithmetic
// reference model, with a per-cycle output compare process.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_i = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op_i = '0;
    logic [XLEN-1:0]  rs1_i = '0;
    logic [XLEN-1:0]  rs2_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {result, tag} of every accepted op, oldest first.
    logic [XLEN+TAG_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_i      (op_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .tag_i     (tag_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .tag_o     (tag_o),
        .busy_o    (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the RISC-V divide-by-zero rule.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        p  = '0;
        case (op)
            3'd0:    p = 64'(ua * ub);
            3'd1:    p = 64'(sa * sb);
            3'd2:    p = 64'(sa * ub);
            3'd3:    p = {32'b0, a} * {32'b0, b};
            3'd4:    p = (b == 0) ? '1 : 64'(sa / sb);
            3'd5:    p = (b == 0) ? '1 : 64'(ua / ub);
            3'd6:    p = (b == 0) ? 64'(ua) : 64'(sa % sb);
            default: p = (b == 0) ? 64'(ua) : 64'(ua % ub);
        endcase
        return (op == 3'd1 || op == 3'd2 || op == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    // Compare process: every cycle a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got result 0x%08h tag %0d, expected no result",
                         result_o, tag_o);
            end else begin
                check("result_o", result_o, exp_q[0][XLEN+TAG_W-1:TAG_W]);
                check("tag_o", 32'(tag_o), 32'(exp_q[0][TAG_W-1:0]));
                if (out_ready) exp_q.delete(0);
            end
        end
    end

    // Issue one op from an idle unit and wait for its result; drains it when out_ready is high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input bit use_lit, input logic [31:0] lit);
        logic [31:0] exp;
        bit special;
        int k;
        exp = ref_result(op, a, b);
        if (use_lit) check($sformatf("model_op%0d_%08h_%08h", op, a, b), exp, lit);
        special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        check("in_ready_idle", 32'(in_ready), 32'd1);
        op_i = op; rs1_i = a; rs2_i = b; tag_i = tag; in_valid = 1'b1;
        exp_q.push_back({exp, tag});
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            if (k == 3) begin
                check("in_ready_busy", 32'(in_ready), 32'd0);
                check("busy_o_calc", 32'(busy_o), 32'd1);
            end
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), special ? 32'd0 : 32'(XLEN));
        if (k >= 200) exp_q.delete();
        $display("op=%0d a=%08h b=%08h tag=%0d -> result=%08h expected=%08h latency=%0d",
                 op, a, b, tag, result_o, exp, k);
        if (out_ready) begin
            @(posedge clk); #1;
            check("out_valid_drained", 32'(out_valid), 32'd0);
            check("in_ready_after_drain", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] ra, rb;
        logic [31:0] held;

        // Reset values while rst_n is low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_tag", 32'(tag_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiply.
        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'h11, 1'b1, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 5'h02, 1'b1, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'h03, 1'b1, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'h04, 1'b1, 32'hFFFF_FFFF);
        run_op(3'd2, 32'd2,          32'h8000_0000, 5'h05, 1'b1, 32'h0000_0001);
        run_op(3'd1, 32'hFFFF_FFFF,  32'd1,         5'h06, 1'b1, 32'hFFFF_FFFF);

        // Divide.
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'h07, 1'b1, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'h08, 1'b1, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd7,          32'd2,         5'h09, 1'b1, 32'd3);
        run_op(3'd7, 32'hFFFF_FFFF,  32'd16,        5'h0A, 1'b1, 32'h0000_000F);
        run_op(3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 5'h0B, 1'b1, 32'd0);
        run_op(3'd6, 32'd7,          32'hFFFF_FFFE, 5'h0C, 1'b1, 32'd1);

        // Special cases: one-cycle results.
        run_op(3'd4, 32'd5,          32'd0,         5'h0D, 1'b1, 32'hFFFF_FFFF);
        run_op(3'd6, 32'd5,          32'd0,         5'h0E, 1'b1, 32'd5);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'h0F, 1'b1, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'h10, 1'b1, 32'd0);
        run_op(3'd5, 32'd0,          32'd0,         5'h12, 1'b1, 32'hFFFF_FFFF);

        // A few random operands scored by the model alone.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 2) ? 32'd3 : $urandom;
            run_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom_range(0, 31)), 1'b0, 32'd0);
        end

        // Backpressure: result and tag hold while out_ready is low.
        out_ready = 1'b0;
        run_op(3'd0, 32'd1000, 32'd1000, 5'h15, 1'b0, 32'd0);
        held = result_o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_result", result_o, held);
            check("hold_tag", 32'(tag_o), 32'h15);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        // New op offered in the drain cycle must not be accepted on that edge.
        op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7; tag_i = 5'h16; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_no_accept_busy", 32'(busy_o), 32'd0);
        check("drain_in_ready_next", 32'(in_ready), 32'd1);
        run_op(3'd5, 32'd100, 32'd7, 5'h16, 1'b1, 32'd14);

        // Flush in the middle of an iteration: nothing is ever emitted.
        op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; tag_i = 5'h17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) cnt++; end
        check("flush_no_result", 32'(cnt), 32'd0);

        // Flush wins over a simultaneous in_valid.
        op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3; tag_i = 5'h18; in_valid = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush_i = 1'b0;
        check("flush_beats_valid", 32'(busy_o), 32'd0);

        // Leave a non-zero result and tag behind so the reset check below is meaningful.
        run_op(3'd0, 32'd6, 32'd7, 5'h1F, 1'b1, 32'd42);

        // Asynchronous reset in the middle of an iteration.
        op_i = 3'd0; rs1_i = 32'd123; rs2_i = 32'd456; tag_i = 5'h19; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_result", result_o, 32'd0);
        check("arst_tag", 32'(tag_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) cnt++; end
        check("arst_no_result", 32'(cnt), 32'd0);

        // Unit still works after reset.
        run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 5'h1A, 1'b1, 32'hFFFF_FFF2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
